snn_conv2d: RTL and testbench

- Event-driven spiking 2D convolution layer with accumulate-only (AC) arithmetic, no multipliers.
- Each AXI-Stream input spike adds weights into the membrane potentials of the output neurons in its receptive field.
- A neuron at or above threshold emits an output spike and resets to zero.
- Weights are fetched from an external 1-cycle-latency memory; usage statistics are exported.

---
 rtl/snn_conv2d_if.sv | 22 ++
 rtl/snn_conv2d.sv | 192 +++++++++++++++++++
 tb/tb_snn_conv2d.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/snn_conv2d_if.sv
// AXI-Stream spike ports of snn_conv2d: input spike stream in, output spike stream out.
// master is the upstream/downstream environment side, slave is the convolution layer side.
interface snn_conv2d_if;
    logic        s_axis_spike_tvalid;
    logic        s_axis_spike_tready;
    logic        s_axis_spike_tlast;
    logic [31:0] s_axis_spike_tdata;
    logic        m_axis_spike_tvalid;
    logic        m_axis_spike_tready;
    logic        m_axis_spike_tlast;
    logic [31:0] m_axis_spike_tdata;

    modport master (
        output s_axis_spike_tvalid, s_axis_spike_tlast, s_axis_spike_tdata, m_axis_spike_tready,
        input  s_axis_spike_tready, m_axis_spike_tvalid, m_axis_spike_tlast, m_axis_spike_tdata
    );

    modport slave (
        input  s_axis_spike_tvalid, s_axis_spike_tlast, s_axis_spike_tdata, m_axis_spike_tready,
        output s_axis_spike_tready, m_axis_spike_tvalid, m_axis_spike_tlast, m_axis_spike_tdata
    );
endinterface

// File: rtl/snn_conv2d.sv
// Event-driven spiking 2D convolution: each input spike accumulates weights into the
// membrane potentials of its receptive field, firing and resetting neurons at threshold.
module snn_conv2d #(
    parameter int INPUT_HEIGHT    = 8,
    parameter int INPUT_WIDTH     = 8,
    parameter int INPUT_CHANNELS  = 1,
    parameter int OUTPUT_CHANNELS = 4,
    parameter int KERNEL_SIZE     = 3,
    parameter int STRIDE          = 1,
    parameter int PADDING         = 1,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int VMEM_WIDTH      = 16,
    parameter int THRESHOLD       = 'h0080,
    parameter int LEAK_SHIFT      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    snn_conv2d_if.slave                    axis,
    output logic                           weight_rd_en,
    output logic [15:0]                    weight_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_data,
    input  logic                           weight_valid,
    input  logic signed [VMEM_WIDTH-1:0]   config_threshold,
    input  logic                           config_valid,
    output logic [31:0]                    input_spike_count,
    output logic [31:0]                    output_spike_count,
    output logic [31:0]                    ac_operation_count,
    output logic [31:0]                    memory_access_count,
    output logic [31:0]                    cycle_count,
    output logic                           busy
);
    localparam int K     = KERNEL_SIZE;
    localparam int OH    = (INPUT_HEIGHT + 2 * PADDING - K) / STRIDE + 1;
    localparam int OW    = (INPUT_WIDTH + 2 * PADDING - K) / STRIDE + 1;
    localparam int NNEUR = OUTPUT_CHANNELS * OH * OW;
    localparam int NW    = (NNEUR > 1) ? $clog2(NNEUR) : 1;

    localparam logic signed [VMEM_WIDTH-1:0] VMAX = {1'b0, {(VMEM_WIDTH-1){1'b1}}};
    localparam logic signed [VMEM_WIDTH-1:0] VMIN = {1'b1, {(VMEM_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_ACC, S_EMIT, S_LEAK} state_t;

    function automatic logic signed [VMEM_WIDTH-1:0] sat_add(
        input logic signed [VMEM_WIDTH-1:0]   a,
        input logic signed [WEIGHT_WIDTH-1:0] b
    );
        logic signed [VMEM_WIDTH:0] s;
        s = {a[VMEM_WIDTH-1], a} + {{(VMEM_WIDTH+1-WEIGHT_WIDTH){b[WEIGHT_WIDTH-1]}}, b};
        if (s[VMEM_WIDTH] != s[VMEM_WIDTH-1]) return s[VMEM_WIDTH] ? VMIN : VMAX;
        return s[VMEM_WIDTH-1:0];
    endfunction

    function automatic logic signed [VMEM_WIDTH-1:0] leak_step(
        input logic signed [VMEM_WIDTH-1:0] v
    );
        return v - (v >>> LEAK_SHIFT);
    endfunction

    state_t                         r_state, w_next;
    logic [7:0]                     r_ch, r_row, r_col, r_ts;
    logic                           r_tlast;
    logic [7:0]                     r_oc, r_kr, r_kc;
    logic [NW-1:0]                  r_leak_idx;
    logic signed [WEIGHT_WIDTH-1:0] r_wt_p0;
    logic signed [VMEM_WIDTH-1:0]   r_thresh;
    logic [31:0]                    r_out_data;
    logic signed [VMEM_WIDTH-1:0]   r_vmem [NNEUR];
    logic [NNEUR-1:0]               r_vvld;

    int                             w_ty, w_tx, w_oy_i, w_ox_i;
    logic                           w_off_valid, w_last, w_adv, w_s_hs, w_we, w_fire;
    logic [7:0]                     w_oy, w_ox;
    logic [15:0]                    w_waddr;
    logic [NW-1:0]                  w_nidx, w_maddr;
    logic signed [VMEM_WIDTH-1:0]   w_rd, w_acc, w_wdata;

    // Receptive-field decode: which output neuron (if any) this kernel offset touches
    always_comb begin
        w_ty        = int'(r_row) + PADDING - int'(r_kr);
        w_tx        = int'(r_col) + PADDING - int'(r_kc);
        w_oy_i      = w_ty / STRIDE;
        w_ox_i      = w_tx / STRIDE;
        w_off_valid = (int'(r_ch) < INPUT_CHANNELS)
                   && (w_ty >= 0) && (w_ty % STRIDE == 0) && (w_oy_i < OH)
                   && (w_tx >= 0) && (w_tx % STRIDE == 0) && (w_ox_i < OW);
        w_oy        = 8'(w_oy_i);
        w_ox        = 8'(w_ox_i);
        w_waddr     = 16'(((int'(r_oc) * INPUT_CHANNELS + int'(r_ch)) * K + int'(r_kr)) * K
                          + int'(r_kc));
        w_nidx      = NW'((int'(r_oc) * OH + w_oy_i) * OW + w_ox_i);
        w_last      = (r_oc == 8'(OUTPUT_CHANNELS - 1)) && (r_kr == 8'(K - 1))
                   && (r_kc == 8'(K - 1));
    end

    // Membrane read-modify-write; unwritten words read as zero until first touched
    always_comb begin
        w_maddr = (r_state == S_LEAK) ? r_leak_idx : w_nidx;
        w_rd    = r_vvld[w_maddr] ? r_vmem[w_maddr] : '0;
        w_acc   = sat_add(w_rd, r_wt_p0);
        w_fire  = (w_acc >= r_thresh);
        w_we    = (r_state == S_ACC) || (r_state == S_LEAK);
        if (r_state == S_LEAK) w_wdata = leak_step(w_rd);
        else                   w_wdata = w_fire ? '0 : w_acc;
    end

    always_comb begin
        w_next = r_state;
        w_adv  = 1'b0;
        w_s_hs = axis.s_axis_spike_tvalid && axis.s_axis_spike_tready;
        case (r_state)
            S_IDLE: if (w_s_hs) w_next = S_SCAN;
            S_SCAN: if (w_off_valid) w_next = S_WAIT; else w_adv = 1'b1;
            S_WAIT: if (weight_valid) w_next = S_ACC;
            S_ACC:  if (w_fire) w_next = S_EMIT; else w_adv = 1'b1;
            S_EMIT: if (axis.m_axis_spike_tready) w_adv = 1'b1;
            S_LEAK: if (r_leak_idx == NW'(NNEUR - 1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_adv) w_next = w_last ? (r_tlast ? S_LEAK : S_IDLE) : S_SCAN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_tlast             <= 1'b0;
            r_oc                <= '0;
            r_kr                <= '0;
            r_kc                <= '0;
            r_leak_idx          <= '0;
            r_thresh            <= VMEM_WIDTH'(THRESHOLD);
            r_out_data          <= '0;
            input_spike_count   <= '0;
            output_spike_count  <= '0;
            ac_operation_count  <= '0;
            memory_access_count <= '0;
            cycle_count         <= '0;
        end else begin
            r_state <= w_next;
            if (config_valid) r_thresh <= config_threshold;
            if (w_s_hs) begin
                r_tlast           <= axis.s_axis_spike_tlast;
                r_oc              <= '0;
                r_kr              <= '0;
                r_kc              <= '0;
                input_spike_count <= input_spike_count + 32'd1;
            end
            // kc innermost, then kr, then oc
            if (w_adv) begin
                if (r_kc == 8'(K - 1)) begin
                    r_kc <= '0;
                    if (r_kr == 8'(K - 1)) begin
                        r_kr <= '0;
                        r_oc <= r_oc + 8'd1;
                    end else begin
                        r_kr <= r_kr + 8'd1;
                    end
                end else begin
                    r_kc <= r_kc + 8'd1;
                end
            end
            r_leak_idx <= (r_state == S_LEAK) ? r_leak_idx + NW'(1) : '0;
            if (weight_rd_en) memory_access_count <= memory_access_count + 32'd1;
            if (r_state == S_ACC) begin
                ac_operation_count <= ac_operation_count + 32'd1;
                if (w_fire) r_out_data <= {r_oc, w_oy, w_ox, r_ts};
            end
            if (r_state == S_EMIT && axis.m_axis_spike_tready)
                output_spike_count <= output_spike_count + 32'd1;
            if (r_state != S_IDLE) cycle_count <= cycle_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s_hs) {r_ch, r_row, r_col, r_ts} <= axis.s_axis_spike_tdata;
        if (r_state == S_WAIT && weight_valid) r_wt_p0 <= weight_data;
        if (w_we) r_vmem[w_maddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) r_vvld <= '0;
        else if (w_we) r_vvld[w_maddr] <= 1'b1;
    end

    assign weight_rd_en             = (r_state == S_SCAN) && w_off_valid;
    assign weight_addr              = weight_rd_en ? w_waddr : 16'd0;
    assign busy                     = (r_state != S_IDLE);
    assign axis.s_axis_spike_tready = enable && (r_state == S_IDLE);
    assign axis.m_axis_spike_tvalid = (r_state == S_EMIT);
    assign axis.m_axis_spike_tdata  = r_out_data;
    assign axis.m_axis_spike_tlast  = 1'b0;
endmodule

// File: tb/tb_snn_conv2d.sv
// Directed bench for snn_conv2d with a 1-cycle weight memory model (mem[a]=(a%8)+1 or -1)
// and hand-computed counter, cycle and output-spike expectations.
module tb_snn_conv2d;
    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              weight_rd_en;
    logic [15:0]       weight_addr;
    logic signed [7:0] weight_data;
    logic              weight_valid;
    logic [15:0]       config_threshold;
    logic              config_valid;
    logic [31:0]       input_spike_count, output_spike_count, ac_operation_count;
    logic [31:0]       memory_access_count, cycle_count;
    logic              busy;
    logic              wneg;
    logic [31:0]       q_out[$];
    int                n_checks = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    snn_conv2d_if vif();

    snn_conv2d dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .axis                (vif.slave),
        .weight_rd_en        (weight_rd_en),
        .weight_addr         (weight_addr),
        .weight_data         (weight_data),
        .weight_valid        (weight_valid),
        .config_threshold    (config_threshold),
        .config_valid        (config_valid),
        .input_spike_count   (input_spike_count),
        .output_spike_count  (output_spike_count),
        .ac_operation_count  (ac_operation_count),
        .memory_access_count (memory_access_count),
        .cycle_count         (cycle_count),
        .busy                (busy)
    );

    always @(posedge clk) begin
        weight_valid <= weight_rd_en;
        weight_data  <= wneg ? -8'sd1 : 8'((weight_addr % 16'd8) + 16'd1);
    end

    always @(negedge clk) begin
        if (!rst && vif.m_axis_spike_tvalid && vif.m_axis_spike_tready)
            q_out.push_back(vif.m_axis_spike_tdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wneg = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        q_out.delete();
        @(negedge clk);
    endtask

    task automatic set_thresh(input logic [15:0] v);
        @(posedge clk); #1;
        config_threshold = v;
        config_valid     = 1'b1;
        @(posedge clk); #1;
        config_valid     = 1'b0;
    endtask

    task automatic send_spike(input logic [7:0] ch, input logic [7:0] row, input logic [7:0] col,
                              input logic [7:0] ts, input logic last);
        int n = 0;
        @(posedge clk); #1;
        vif.s_axis_spike_tvalid = 1'b1;
        vif.s_axis_spike_tdata  = {ch, row, col, ts};
        vif.s_axis_spike_tlast  = last;
        @(negedge clk);
        while (!vif.s_axis_spike_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        vif.s_axis_spike_tvalid = 1'b0;
        vif.s_axis_spike_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_counts(input string tag, input int ins, input int outs, input int acs,
                              input int mems);
        chk({tag, ".in"},  input_spike_count,   32'(ins));
        chk({tag, ".out"}, output_spike_count,  32'(outs));
        chk({tag, ".ac"},  ac_operation_count,  32'(acs));
        chk({tag, ".mem"}, memory_access_count, 32'(mems));
    endtask

    initial begin
        logic [31:0] d0;
        int          n;
        int          idx;
        rst = 1'b1;
        enable = 1'b1;
        wneg = 1'b0;
        config_threshold = '0;
        config_valid = 1'b0;
        vif.s_axis_spike_tvalid = 1'b0;
        vif.s_axis_spike_tdata  = '0;
        vif.s_axis_spike_tlast  = 1'b0;
        vif.m_axis_spike_tready = 1'b1;

        do_reset();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.tready", 32'(vif.s_axis_spike_tready), 32'd1);
        chk("rst.mvalid", 32'(vif.m_axis_spike_tvalid), 32'd0);
        chk("rst.rd_en", 32'(weight_rd_en), 32'd0);
        chk("rst.cycles", cycle_count, 32'd0);
        chk_counts("rst", 0, 0, 0, 0);
        @(posedge clk); #1 enable = 1'b0;
        @(negedge clk);
        chk("en0.tready", 32'(vif.s_axis_spike_tready), 32'd0);
        @(posedge clk); #1 enable = 1'b1;

        // Centre spike with tlast: 36 accumulates then a 256-neuron leak pass
        send_spike(8'd0, 8'd4, 8'd4, 8'd100, 1'b1);
        wait_idle("centre");
        chk_counts("centre", 1, 0, 36, 36);
        chk("centre.cycles", cycle_count, 32'd364);

        // Corner spike plus out-of-range channel and row: only 16 valid offsets
        do_reset();
        send_spike(8'd0, 8'd0, 8'd0, 8'd1, 1'b0);
        wait_idle("corner");
        chk_counts("corner", 1, 0, 16, 16);
        chk("corner.cycles", cycle_count, 32'd68);
        send_spike(8'd1, 8'd4, 8'd4, 8'd2, 1'b0);
        wait_idle("badch");
        send_spike(8'd0, 8'd200, 8'd4, 8'd3, 1'b0);
        wait_idle("badrow");
        chk_counts("oor", 3, 0, 16, 16);
        chk("oor.cycles", cycle_count, 32'd140);

        do_reset();
        send_spike(8'd0, 8'd1, 8'd1, 8'd10, 1'b0); wait_idle("d1");
        send_spike(8'd0, 8'd3, 8'd3, 8'd11, 1'b0); wait_idle("d2");
        send_spike(8'd0, 8'd5, 8'd5, 8'd12, 1'b0); wait_idle("d3");
        send_spike(8'd0, 8'd2, 8'd6, 8'd13, 1'b0); wait_idle("d4");
        send_spike(8'd0, 8'd6, 8'd2, 8'd14, 1'b1); wait_idle("d5");
        chk_counts("diag", 5, 0, 180, 180);

        do_reset();
        for (int r = 0; r < 8; r += 2) begin
            for (int c = 0; c < 8; c += 2) begin
                send_spike(8'd0, 8'(r), 8'(c), 8'(r * 8 + c), (r == 6 && c == 6));
                wait_idle("grid");
            end
        end
        chk_counts("grid", 16, 0, 484, 484);

        // Threshold 1: every touched neuron fires; first spike is stalled downstream
        do_reset();
        set_thresh(16'd1);
        @(posedge clk); #1 vif.m_axis_spike_tready = 1'b0;
        send_spike(8'd0, 8'd4, 8'd4, 8'd55, 1'b0);
        n = 0;
        while (!vif.m_axis_spike_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall.valid", 32'(vif.m_axis_spike_tvalid), 32'd1);
        d0 = vif.m_axis_spike_tdata;
        chk("stall.first", d0, {8'd0, 8'd5, 8'd5, 8'd55});
        repeat (4) begin
            @(negedge clk);
            chk("stall.data", vif.m_axis_spike_tdata, d0);
            chk("stall.outcnt", output_spike_count, 32'd0);
            chk("stall.ac", ac_operation_count, 32'd1);
        end
        @(posedge clk); #1 vif.m_axis_spike_tready = 1'b1;
        wait_idle("fire");
        chk_counts("fire", 1, 36, 36, 36);
        chk("fire.qsize", 32'(q_out.size()), 32'd36);
        idx = 0;
        for (int oc = 0; oc < 4; oc++) begin
            for (int kr = 0; kr < 3; kr++) begin
                for (int kc = 0; kc < 3; kc++) begin
                    if (idx < q_out.size())
                        chk("fire.spike", q_out[idx],
                            {8'(oc), 8'(5 - kr), 8'(5 - kc), 8'd55});
                    idx++;
                end
            end
        end
        // Fired neurons must restart from zero: weights 1..8 stay below 9
        set_thresh(16'd9);
        send_spike(8'd0, 8'd4, 8'd4, 8'd56, 1'b0);
        wait_idle("refire");
        chk_counts("refire", 2, 36, 72, 72);

        do_reset();
        set_thresh(16'd1);
        wneg = 1'b1;
        send_spike(8'd0, 8'd4, 8'd4, 8'd60, 1'b0);
        wait_idle("neg");
        chk_counts("neg", 1, 0, 36, 36);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
